// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side master for the synchronous FIFO. On request it pops a programmed
// number of words from the FIFO (first-word-fall-through head on i_data) and
// forwards them downstream through a single registered output stage, marking
// the final word of the burst with o_last.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds valid and data
// stable until that edge; ready may change freely. Here the FIFO side is
// (i_valid_m, o_ready_m) and the downstream side is (o_valid, i_ready).
//
// Optional feature (macro FIFO_BURST_RD_FILL_WAIT_EN):
//   defined   - WAIT_FILL holds until the FIFO is no longer almost empty, or
//               the burst is at most MIN_BURST words long.
//   undefined - WAIT_FILL lasts exactly one cycle; i_almostempty is ignored.
//
// Parameters:
//   DATA_WIDTH  FIFO / stream data width
//   LEN_WIDTH   width of the burst-length field
//   MIN_BURST   short-burst threshold for the fill wait (must fit LEN_WIDTH)
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   i_start          burst request, sampled in IDLE only
//   i_burst_len      words in the burst, latched with i_start
//   i_valid_m        FIFO not empty
//   i_almostempty    FIFO almost-empty flag
//   i_data           FIFO head word
//   o_ready_m        pop request to the FIFO
//   o_valid, o_data  downstream beat
//   o_last           final beat of the burst
//   i_ready          downstream accept
//   o_busy           burst in progress (any state except IDLE)
//   o_done           one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int MIN_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_burst_len,
  input  logic                  i_valid_m,
  input  logic                  i_almostempty,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready_m,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FILL = 3'd1,
    S_READ      = 3'd2,
    S_FLUSH     = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic pop;       // FIFO word consumed on this edge
  logic beat;      // downstream beat accepted on this edge
  logic fill_ok;   // WAIT_FILL may advance to READ
  logic ready_m;

`ifdef FIFO_BURST_RD_FILL_WAIT_EN
  // No pops happen in WAIT_FILL, so rem_q still equals the latched length.
  assign fill_ok = !i_almostempty || (rem_q <= LEN_WIDTH'(MIN_BURST));
`else
  assign fill_ok = 1'b1;
  logic                 unused_almostempty;
  logic [LEN_WIDTH-1:0] unused_min_burst;
  assign unused_almostempty = i_almostempty;
  assign unused_min_burst   = LEN_WIDTH'(MIN_BURST);
`endif

  // Pop only while words remain and the output register is free or being
  // emptied this same cycle; that keeps at most one word inside the block.
  assign ready_m = (state_q == S_READ) && (rem_q != '0) && (!valid_q || i_ready);
  assign pop     = ready_m && i_valid_m;
  assign beat    = valid_q && i_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;

    // Output register: drain on accept, reload on pop. A simultaneous pop
    // and accept reloads and keeps valid high (one word per cycle).
    if (beat) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (pop) begin
      valid_d = 1'b1;
      data_d  = i_data;
      last_d  = (rem_q == LEN_WIDTH'(1));
      rem_d   = rem_q - LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rem_d   = i_burst_len;
          state_d = (i_burst_len == '0) ? S_DONE : S_WAIT_FILL;
        end
      end
      S_WAIT_FILL: begin
        if (fill_ok) state_d = S_READ;
      end
      S_READ: begin
        if (pop && (rem_q == LEN_WIDTH'(1))) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (beat && last_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_ready_m = ready_m;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Directed + randomized bench for fifo_burst_reader. The FIFO is a queue
// owned by the bench; every word written is also pushed to the expected
// queue, and each burst of N beats must deliver the next N written words in
// order, with last on the Nth, done one cycle after the final accept, and
// exactly N pops. LEN_WIDTH is reduced so the all-ones burst length is short.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW   = 8;
  localparam int LW   = 8;
  localparam int MINB = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [LW-1:0] i_burst_len;
  logic          i_valid_m;
  logic          i_almostempty;
  logic [DW-1:0] i_data;
  logic          o_ready_m;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          i_ready;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .MIN_BURST  (MINB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_burst_len   (i_burst_len),
    .i_valid_m     (i_valid_m),
    .i_almostempty (i_almostempty),
    .i_data        (i_data),
    .o_ready_m     (o_ready_m),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .o_last        (o_last),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  // ---------------- scoreboard / reference model state ----------------
  logic [DW-1:0] fifo_q[$];   // bench FIFO contents
  logic [DW-1:0] exp_q[$];    // words expected downstream, in order

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  int cyc      = 0;

  int burst_len_m, beat_m, pops_m;
  bit busy_m, done_due, popped_prev, stalled_prev;
  logic [DW-1:0] pop_word, prev_data;
  logic          prev_last;
  int rdy_mode, rdy_idx, feed_pct;
  int start_cyc, first_beat_cyc, last_beat_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    i_valid_m = (fifo_q.size() != 0);
    i_data    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  task automatic next_ready();
    case (rdy_mode)
      1:       i_ready = ((rdy_idx % 3) == 0);   // 1,0,0,1,0,0,...
      2:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b1;
    endcase
    rdy_idx++;
  endtask

  // One clock cycle: check at the falling edge, apply effects after the
  // rising edge.
  task automatic cycle();
    logic will_pop, will_xfer;
    bit   done_next, busy_next;
    logic [DW-1:0] w;
    @(negedge clk);
    cyc++;
    check("o_done", 32'(o_done), 32'(done_due));
    check("o_busy", 32'(o_busy), 32'(busy_m));
    if (popped_prev) begin
      check("pop_to_valid", 32'(o_valid), 32'(1));
      check("pop_to_data", 32'(o_data), 32'(pop_word));
    end
    if (stalled_prev)
      check("stall_hold", 32'({o_valid, o_last, o_data}), 32'({1'b1, prev_last, prev_data}));
    if (o_valid && !i_ready)
      check("ready_m_in_stall", 32'(o_ready_m), 32'(0));
    if (!busy_m)
      check("idle_quiet", 32'({o_ready_m, o_valid}), 32'(0));

    will_pop  = o_ready_m && i_valid_m;
    will_xfer = o_valid && i_ready;
    done_next = 1'b0;
    busy_next = busy_m;

    if (will_pop) begin
      pops_m++;
      check("pop_within_len", 32'(pops_m <= burst_len_m), 32'(1));
    end
    if (will_xfer) begin
      check("beat_expected", 32'((exp_q.size() != 0) && (beat_m < burst_len_m)), 32'(1));
      if ((exp_q.size() != 0) && (beat_m < burst_len_m)) begin
        w = exp_q.pop_front();
        check("beat_data", 32'(o_data), 32'(w));
        check("beat_last", 32'(o_last), 32'(beat_m == burst_len_m - 1));
      end
      if (beat_m == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beat_m++;
      if (beat_m == burst_len_m) done_next = 1'b1;
    end
    if (done_due) begin
      check("pops_per_burst", 32'(pops_m), 32'(burst_len_m));
      check("beats_per_burst", 32'(beat_m), 32'(burst_len_m));
      busy_next = 1'b0;
    end
    if (i_start && !busy_m) begin
      burst_len_m = int'(i_burst_len);
      beat_m      = 0;
      pops_m      = 0;
      busy_next   = 1'b1;
      start_cyc   = cyc;
      if (i_burst_len == '0) done_next = 1'b1;
    end

    stalled_prev = o_valid && !i_ready;
    prev_data    = o_data;
    prev_last    = o_last;
    pop_word     = i_data;
    popped_prev  = will_pop;

    @(posedge clk);
    #1;
    if (will_pop) void'(fifo_q.pop_front());
    done_due = done_next;
    busy_m   = busy_next;
    if ((feed_pct > 0) && (fifo_q.size() < 16) && ($urandom_range(0, 99) < feed_pct))
      fifo_write(DW'($urandom_range(0, 255)));
    drive_fifo();
    next_ready();
  endtask

  task automatic start_burst(input int len);
    i_burst_len = LW'(len);
    i_start     = 1'b1;
    cycle();
    i_start     = 1'b0;
    i_burst_len = LW'($urandom_range(0, 255));   // must not disturb the burst
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy_m && (n < budget)) begin
      cycle();
      n++;
    end
    check("burst_finished", 32'(o_busy), 32'(0));
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'(0));
    check("rst_last", 32'(o_last), 32'(0));
    check("rst_done", 32'(o_done), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_ready_m", 32'(o_ready_m), 32'(0));
    check("rst_data", 32'(o_data), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    busy_m = 0; done_due = 0; popped_prev = 0; stalled_prev = 0;
    burst_len_m = 0; beat_m = 0; pops_m = 0;
    drive_fifo();
    next_ready();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; i_start = 1'b0; i_burst_len = '0; i_almostempty = 1'b0;
    i_valid_m = 1'b0; i_data = '0; i_ready = 1'b1;
    rdy_mode = 0; rdy_idx = 0; feed_pct = 0;
    do_reset();

    // Single burst of 4 with free-flowing downstream.
    for (int i = 0; i < 4; i++) fifo_write(DW'(8'h10 + i));
    start_burst(4);
    run_until_idle(50);
    check("single_first_latency", 32'(first_beat_cyc - start_cyc), 32'(3));
    check("single_consecutive", 32'(last_beat_cyc - first_beat_cyc), 32'(3));

    // Zero length: words waiting in the FIFO must not be touched.
    fifo_write(8'hA0);
    fifo_write(8'hA1);
    start_burst(0);
    run_until_idle(10);

    // Backpressure, plus an i_start mid-burst that must be ignored.
    fifo_write(8'h31);
    rdy_mode = 1; rdy_idx = 0;
    start_burst(3);
    i_start = 1'b1; i_burst_len = LW'(9);
    cycle();
    i_start = 1'b0;
    run_until_idle(60);

    // Underflow: 2 words now, 3 more after 10 cycles.
    rdy_mode = 0;
    fifo_write(8'h50);
    fifo_write(8'h51);
    start_burst(5);
    for (int i = 0; i < 10; i++) cycle();
    check("underflow_partial", 32'(beat_m), 32'(2));
    for (int i = 0; i < 3; i++) fifo_write(DW'(8'h52 + i));
    run_until_idle(40);

`ifdef FIFO_BURST_RD_FILL_WAIT_EN
    // Fill wait: long burst holds while almost empty, short one does not.
    for (int i = 0; i < 8; i++) fifo_write(DW'(8'h60 + i));
    i_almostempty = 1'b1;
    start_burst(8);
    for (int i = 0; i < 6; i++) begin
      check("fill_wait_no_pop", 32'(o_ready_m), 32'(0));
      cycle();
    end
    i_almostempty = 1'b0;
    run_until_idle(40);
    check("fill_wait_latency", 32'(first_beat_cyc - start_cyc), 32'(9));
    for (int i = 0; i < 3; i++) fifo_write(DW'(8'h68 + i));
    i_almostempty = 1'b1;
    start_burst(3);
    run_until_idle(40);
    check("short_burst_latency", 32'(first_beat_cyc - start_cyc), 32'(3));
    i_almostempty = 1'b0;
`endif

    // Randomized bursts with random backpressure and FIFO refill.
    rdy_mode = 2; feed_pct = 60;
    for (int b = 0; b < 10; b++) begin
      start_burst($urandom_range(1, 20));
      run_until_idle(400);
    end

    // Longest burst the length field can express.
    feed_pct = 70;
    start_burst((1 << LW) - 1);
    run_until_idle(3000);

    // Reset mid-burst, then a fresh burst of 2.
    rdy_mode = 0; feed_pct = 0;
    next_ready();
    for (int i = 0; i < 6; i++) fifo_write(DW'(8'h80 + i));
    start_burst(6);
    for (int n = 0; (n < 20) && (beat_m < 2); n++) cycle();
    check("pre_reset_beats", 32'(beat_m), 32'(2));
    do_reset();
    fifo_write(8'h71);
    fifo_write(8'h72);
    start_burst(2);
    run_until_idle(20);
    check("post_reset_beats", 32'(beat_m), 32'(2));
    for (int i = 0; i < 3; i++) cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
